stack_arbiter: RTL and testbench

- Shares one `stack` instance between two independent requesters (A, B).
- Each requester issues push or pop requests over a req/gnt handshake. The arbiter picks a winner round-robin and drives the stack's PUSH/POP/DATA_IN strobes.
- It returns popped data with a valid pulse, and rejects ops that would overflow or underflow the stack.
- Sits between the top-level pin logic and `stack`.

---
 rtl/stack_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_stack_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack between requesters A and B.
// Optional occupancy counter and OCC port enabled by defining STACK_ARB_OCC_EN.
module stack_arbiter #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ_A,
  input  logic             OP_A,
  input  logic [WIDTH-1:0] WDATA_A,
  output logic             GNT_A,
  output logic             RVALID_A,
  output logic             ERR_A,
  output logic [WIDTH-1:0] RDATA_A,
  input  logic             REQ_B,
  input  logic             OP_B,
  input  logic [WIDTH-1:0] WDATA_B,
  output logic             GNT_B,
  output logic             RVALID_B,
  output logic             ERR_B,
  output logic [WIDTH-1:0] RDATA_B,
  output logic             STK_PUSH,
  output logic             STK_POP,
  output logic [WIDTH-1:0] STK_DATA_IN,
  input  logic [WIDTH-1:0] STK_DATA_OUT,
  input  logic             STK_FULL,
  input  logic             STK_EMPTY
`ifdef STACK_ARB_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] OCC
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  if (DEPTH < 1) begin : g_depth_chk
    $error("stack_arbiter: DEPTH must be at least 1");
  end

  state_t             r_state, w_state_nxt;
  logic               r_last, w_last_nxt;
  logic               r_win, w_win_nxt;
  logic               r_gnt_a, r_gnt_b, r_err_a, r_err_b, r_rvalid_a, r_rvalid_b;
  logic               w_gnt_a_nxt, w_gnt_b_nxt, w_err_a_nxt, w_err_b_nxt;
  logic               w_rvalid_a_nxt, w_rvalid_b_nxt;
  logic [WIDTH-1:0]   r_rdata_a, r_rdata_b, w_rdata_a_nxt, w_rdata_b_nxt;
  logic               r_stk_push, r_stk_pop, w_stk_push_nxt, w_stk_pop_nxt;
  logic [WIDTH-1:0]   r_stk_din, w_stk_din_nxt;

  logic               w_any, w_sel, w_op, w_legal, w_full_chk, w_empty_chk;
  logic [WIDTH-1:0]   w_wdata;

`ifdef STACK_ARB_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_occ <= '0;
    end else if (r_stk_push && (r_occ != OCC_MAX)) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (r_stk_pop && (r_occ != '0)) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign OCC         = r_occ;
  assign w_full_chk  = STK_FULL  | (r_occ == OCC_MAX);
  assign w_empty_chk = STK_EMPTY | (r_occ == '0);
`else
  assign w_full_chk  = STK_FULL;
  assign w_empty_chk = STK_EMPTY;
`endif

  // With both requesting, the side that did not win last time goes first.
  assign w_any   = REQ_A | REQ_B;
  assign w_sel   = (REQ_A & REQ_B) ? ~r_last : REQ_B;
  assign w_op    = (w_sel == SEL_B) ? OP_B : OP_A;
  assign w_wdata = (w_sel == SEL_B) ? WDATA_B : WDATA_A;
  assign w_legal = w_op ? ~w_empty_chk : ~w_full_chk;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_win_nxt      = r_win;
    w_gnt_a_nxt    = 1'b0;
    w_gnt_b_nxt    = 1'b0;
    w_err_a_nxt    = 1'b0;
    w_err_b_nxt    = 1'b0;
    w_rvalid_a_nxt = 1'b0;
    w_rvalid_b_nxt = 1'b0;
    w_stk_push_nxt = 1'b0;
    w_stk_pop_nxt  = 1'b0;
    w_stk_din_nxt  = r_stk_din;
    w_rdata_a_nxt  = r_rdata_a;
    w_rdata_b_nxt  = r_rdata_b;

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_last_nxt  = w_sel;
          w_win_nxt   = w_sel;
          w_gnt_a_nxt = (w_sel == SEL_A);
          w_gnt_b_nxt = (w_sel == SEL_B);
          if (w_legal) begin
            w_stk_push_nxt = ~w_op;
            w_stk_pop_nxt  = w_op;
            if (!w_op) w_stk_din_nxt = w_wdata;
            w_state_nxt = ISSUE;
          end else begin
            w_err_a_nxt = (w_sel == SEL_A);
            w_err_b_nxt = (w_sel == SEL_B);
            w_state_nxt = SETTLE;
          end
        end
      end
      ISSUE: begin
        // Stack pops at this edge; DATA_OUT still shows the pre-pop top.
        if (r_stk_pop) begin
          if (r_win == SEL_B) begin
            w_rdata_b_nxt  = STK_DATA_OUT;
            w_rvalid_b_nxt = 1'b1;
          end else begin
            w_rdata_a_nxt  = STK_DATA_OUT;
            w_rvalid_a_nxt = 1'b1;
          end
        end
        w_state_nxt = SETTLE;
      end
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_last     <= SEL_B;
      r_win      <= SEL_A;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_err_a    <= 1'b0;
      r_err_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_stk_push <= 1'b0;
      r_stk_pop  <= 1'b0;
      r_stk_din  <= '0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_win      <= w_win_nxt;
      r_gnt_a    <= w_gnt_a_nxt;
      r_gnt_b    <= w_gnt_b_nxt;
      r_err_a    <= w_err_a_nxt;
      r_err_b    <= w_err_b_nxt;
      r_rvalid_a <= w_rvalid_a_nxt;
      r_rvalid_b <= w_rvalid_b_nxt;
      r_stk_push <= w_stk_push_nxt;
      r_stk_pop  <= w_stk_pop_nxt;
      r_stk_din  <= w_stk_din_nxt;
      r_rdata_a  <= w_rdata_a_nxt;
      r_rdata_b  <= w_rdata_b_nxt;
    end
  end

  assign GNT_A       = r_gnt_a;
  assign GNT_B       = r_gnt_b;
  assign ERR_A       = r_err_a;
  assign ERR_B       = r_err_b;
  assign RVALID_A    = r_rvalid_a;
  assign RVALID_B    = r_rvalid_b;
  assign RDATA_A     = r_rdata_a;
  assign RDATA_B     = r_rdata_b;
  assign STK_PUSH    = r_stk_push;
  assign STK_POP     = r_stk_pop;
  assign STK_DATA_IN = r_stk_din;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed self-checking bench for stack_arbiter with a behavioural 4-deep stack.
// Define STACK_ARB_OCC_EN for both files to also check the OCC port.
module tb_stack_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       REQ_A, OP_A, REQ_B, OP_B;
  logic [1:0] WDATA_A, WDATA_B;
  logic       GNT_A, RVALID_A, ERR_A, GNT_B, RVALID_B, ERR_B;
  logic [1:0] RDATA_A, RDATA_B;
  logic       STK_PUSH, STK_POP, STK_FULL, STK_EMPTY;
  logic [1:0] STK_DATA_IN, STK_DATA_OUT;
`ifdef STACK_ARB_OCC_EN
  logic [2:0] OCC;
`endif

  int n_pass  = 0;
  int n_total = 0;

  stack_arbiter #(.WIDTH(2), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_A(REQ_A), .OP_A(OP_A), .WDATA_A(WDATA_A),
    .GNT_A(GNT_A), .RVALID_A(RVALID_A), .ERR_A(ERR_A), .RDATA_A(RDATA_A),
    .REQ_B(REQ_B), .OP_B(OP_B), .WDATA_B(WDATA_B),
    .GNT_B(GNT_B), .RVALID_B(RVALID_B), .ERR_B(ERR_B), .RDATA_B(RDATA_B),
    .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_DATA_IN(STK_DATA_IN),
    .STK_DATA_OUT(STK_DATA_OUT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY)
`ifdef STACK_ARB_OCC_EN
    , .OCC(OCC)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural stack sharing the arbiter's reset.
  logic [1:0] mem [4];
  logic [2:0] cnt;
  logic [2:0] top_idx;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= 3'd0;
    end else if (STK_PUSH && cnt < 3'd4) begin
      mem[cnt[1:0]] <= STK_DATA_IN;
      cnt <= cnt + 3'd1;
    end else if (STK_POP && cnt > 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign top_idx      = cnt - 3'd1;
  assign STK_DATA_OUT = (cnt != 3'd0) ? mem[top_idx[1:0]] : 2'b00;
  assign STK_FULL     = (cnt == 3'd4);
  assign STK_EMPTY    = (cnt == 3'd0);

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    REQ_A = 1'b0; OP_A = 1'b0; WDATA_A = 2'b00;
    REQ_B = 1'b0; OP_B = 1'b0; WDATA_B = 2'b00;
    repeat (2) @(posedge CLK);
    #3;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    REQ_A = 1'b0; OP_A = 1'b0; WDATA_A = 2'b00;
    REQ_B = 1'b0; OP_B = 1'b0; WDATA_B = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if ({GNT_A, GNT_B, RVALID_A, RVALID_B, ERR_A, ERR_B, STK_PUSH, STK_POP} !== 8'h00)
      $display("FAIL reset_strobes: got %b want 00000000",
               {GNT_A, GNT_B, RVALID_A, RVALID_B, ERR_A, ERR_B, STK_PUSH, STK_POP});
    else n_pass++;
    n_total++;
    if ({RDATA_A, RDATA_B, STK_DATA_IN} !== 6'h00)
      $display("FAIL reset_data: got %b want 000000", {RDATA_A, RDATA_B, STK_DATA_IN});
    else n_pass++;
`ifdef STACK_ARB_OCC_EN
    n_total++;
    if (OCC !== 3'd0) $display("FAIL reset_occ: got %0d want 0", OCC);
    else n_pass++;
`endif
    RST_N = 1'b1;
    tick();
    n_total++;
    if ({GNT_A, GNT_B, STK_PUSH, STK_POP} !== 4'b0000)
      $display("FAIL idle_no_req: got %b want 0000", {GNT_A, GNT_B, STK_PUSH, STK_POP});
    else n_pass++;
  endtask

  task automatic test_underflow;
    OP_A = 1'b1; REQ_A = 1'b1;
    tick();
    n_total++;
    if ({GNT_A, ERR_A, STK_POP, RVALID_A} !== 4'b1100)
      $display("FAIL underflow_a_gnt_err: got %b want 1100", {GNT_A, ERR_A, STK_POP, RVALID_A});
    else n_pass++;
    REQ_A = 1'b0;
    tick();
    n_total++;
    if ({GNT_A, ERR_A, RVALID_A, STK_POP, RDATA_A} !== 6'b000000)
      $display("FAIL underflow_a_after: got %b want 000000", {GNT_A, ERR_A, RVALID_A, STK_POP, RDATA_A});
    else n_pass++;
    // Rejected op returns to IDLE two cycles after the sample.
    OP_B = 1'b1; REQ_B = 1'b1;
    tick();
    n_total++;
    if ({GNT_B, ERR_B, STK_POP} !== 3'b110)
      $display("FAIL underflow_b_gnt_err: got %b want 110", {GNT_B, ERR_B, STK_POP});
    else n_pass++;
    REQ_B = 1'b0;
    tick();
    n_total++;
    if ({RVALID_B, RDATA_B} !== 3'b000)
      $display("FAIL underflow_b_no_rvalid: got %b want 000", {RVALID_B, RDATA_B});
    else n_pass++;
  endtask

  task automatic test_single_push;
    OP_A = 1'b0; WDATA_A = 2'b10; REQ_A = 1'b1;
    tick();
    n_total++;
    if ({GNT_A, ERR_A, STK_PUSH, STK_POP, STK_DATA_IN} !== 6'b101010)
      $display("FAIL push_strobe: got %b want 101010", {GNT_A, ERR_A, STK_PUSH, STK_POP, STK_DATA_IN});
    else n_pass++;
    REQ_A = 1'b0;
    OP_B = 1'b1; REQ_B = 1'b1;   // raised in ISSUE: must wait for IDLE
    tick();
    n_total++;
    if ({GNT_A, GNT_B, STK_PUSH} !== 3'b000)
      $display("FAIL push_issue_clear: got %b want 000", {GNT_A, GNT_B, STK_PUSH});
    else n_pass++;
    tick();
    n_total++;
    if (GNT_B !== 1'b0) $display("FAIL req_ignored_settle: got %b want 0", GNT_B);
    else n_pass++;
    tick();
    n_total++;
    if ({GNT_B, STK_POP, ERR_B} !== 3'b110)
      $display("FAIL idle_at_plus3_pop: got %b want 110", {GNT_B, STK_POP, ERR_B});
    else n_pass++;
    REQ_B = 1'b0;
    tick();
    n_total++;
    if ({RVALID_B, RDATA_B, RVALID_A, RDATA_A} !== 6'b110000)
      $display("FAIL pop_b_data10: got %b want 110000", {RVALID_B, RDATA_B, RVALID_A, RDATA_A});
    else n_pass++;
    tick();
    n_total++;
    if (RVALID_B !== 1'b0) $display("FAIL rvalid_pulse: got %b want 0", RVALID_B);
    else n_pass++;
  endtask

  task automatic test_push_pop;
    OP_A = 1'b0; WDATA_A = 2'b01; REQ_A = 1'b1;
    tick();
    n_total++;
    if ({GNT_A, STK_PUSH, STK_DATA_IN} !== 4'b1101)
      $display("FAIL pp_push: got %b want 1101", {GNT_A, STK_PUSH, STK_DATA_IN});
    else n_pass++;
    REQ_A = 1'b0;
    tick(); tick();
    OP_B = 1'b1; REQ_B = 1'b1;
    tick();
    n_total++;
    if ({GNT_B, STK_POP, ERR_B, STK_PUSH} !== 4'b1100)
      $display("FAIL pp_pop: got %b want 1100", {GNT_B, STK_POP, ERR_B, STK_PUSH});
    else n_pass++;
    REQ_B = 1'b0;
    tick();
    n_total++;
    if ({RVALID_B, RDATA_B, RVALID_A, RDATA_A} !== 6'b101000)
      $display("FAIL pp_rdata: got %b want 101000", {RVALID_B, RDATA_B, RVALID_A, RDATA_A});
    else n_pass++;
    tick();
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) begin
      OP_A = 1'b0; WDATA_A = 2'(i); REQ_A = 1'b1;
      tick();
      n_total++;
      if ({GNT_A, ERR_A, STK_PUSH} !== 3'b101)
        $display("FAIL ovf_fill_%0d: got %b want 101", i, {GNT_A, ERR_A, STK_PUSH});
      else n_pass++;
      REQ_A = 1'b0;
      tick(); tick();
    end
`ifdef STACK_ARB_OCC_EN
    n_total++;
    if (OCC !== 3'd4) $display("FAIL occ_full_before: got %0d want 4", OCC);
    else n_pass++;
`endif
    WDATA_A = 2'b10; REQ_A = 1'b1;
    tick();
    n_total++;
    if ({GNT_A, ERR_A, STK_PUSH} !== 3'b110)
      $display("FAIL ovf_reject: got %b want 110", {GNT_A, ERR_A, STK_PUSH});
    else n_pass++;
    REQ_A = 1'b0;
    tick();
`ifdef STACK_ARB_OCC_EN
    n_total++;
    if (OCC !== 3'd4) $display("FAIL occ_full_after: got %0d want 4", OCC);
    else n_pass++;
`endif
    // Drain in LIFO order: 3, 2, 1, 0.
    for (int i = 3; i >= 0; i--) begin
      OP_B = 1'b1; REQ_B = 1'b1;
      tick();
      REQ_B = 1'b0;
      tick();
      n_total++;
      if ({RVALID_B, RDATA_B} !== {1'b1, 2'(i)})
        $display("FAIL drain_%0d: got %b want %b", i, {RVALID_B, RDATA_B}, {1'b1, 2'(i)});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_contention;
    logic [1:0] exp_gnt;
    logic [1:0] exp_din;
    do_reset();
    OP_A = 1'b0; WDATA_A = 2'b01; REQ_A = 1'b1;
    OP_B = 1'b0; WDATA_B = 2'b10; REQ_B = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_gnt = (k == 1 || k == 7) ? 2'b10 : (k == 4 || k == 10) ? 2'b01 : 2'b00;
      n_total++;
      if ({GNT_A, GNT_B} !== exp_gnt)
        $display("FAIL rr_gnt_cycle%0d: got %b want %b", k, {GNT_A, GNT_B}, exp_gnt);
      else n_pass++;
      if (exp_gnt != 2'b00) begin
        exp_din = exp_gnt[1] ? 2'b01 : 2'b10;
        n_total++;
        if (STK_DATA_IN !== exp_din)
          $display("FAIL rr_din_cycle%0d: got %b want %b", k, STK_DATA_IN, exp_din);
        else n_pass++;
      end
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op;
    OP_B = 1'b1; REQ_B = 1'b1;
    tick();
    n_total++;
    if ({GNT_B, STK_POP} !== 2'b11)
      $display("FAIL midop_pop_issued: got %b want 11", {GNT_B, STK_POP});
    else n_pass++;
    REQ_B = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    n_total++;
    if ({GNT_A, GNT_B, RVALID_A, RVALID_B, ERR_A, ERR_B, STK_PUSH, STK_POP,
         RDATA_A, RDATA_B, STK_DATA_IN} !== 14'h0)
      $display("FAIL midop_async_reset: got %b want all zero",
               {GNT_A, GNT_B, RVALID_A, RVALID_B, ERR_A, ERR_B, STK_PUSH, STK_POP,
                RDATA_A, RDATA_B, STK_DATA_IN});
    else n_pass++;
    #2 RST_N = 1'b1;
    OP_A = 1'b0; WDATA_A = 2'b11; REQ_A = 1'b1;
    OP_B = 1'b0; WDATA_B = 2'b01; REQ_B = 1'b1;
    tick();
    n_total++;
    if ({GNT_A, GNT_B, STK_PUSH} !== 3'b101)
      $display("FAIL midop_first_gnt_a: got %b want 101", {GNT_A, GNT_B, STK_PUSH});
    else n_pass++;
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_underflow();
    test_single_push();
    test_push_pop();
    test_overflow();
    test_contention();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
